// File: rtl/md_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    localparam int unsigned MD_DEFAULT_WIDTH = 32;

    // Iteration counter width; it counts WIDTH-1 down to 0.
    function automatic int unsigned md_cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/md_neg.sv
// Conditional two's-complement negate of a W-bit value.
module md_neg #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] x_i,
    input  logic         neg_i,
    output logic [W-1:0] y_c
);

    assign y_c = neg_i ? (W'(0) - x_i) : x_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide over a shared 2*WIDTH accumulator,
// with a start/busy/done handshake and registered Hi/Lo results.
module muldiv_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int unsigned CW = md_cnt_width(WIDTH);
    localparam int unsigned W2 = 2 * WIDTH;

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    md_op_e           op_q, op_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
    logic             dz_q, dz_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divz_q, divz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    md_op_e           op_c;
    logic             signed_c;
    logic             is_div_c;
    logic             run_div_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH:0]   sum_c;
    logic [W2-1:0]    mul_next_c;
    logic [WIDTH:0]   trial_c;
    logic [WIDTH:0]   diff_c;
    logic             ge_c;
    logic [W2-1:0]    div_next_c;
    logic [W2-1:0]    prod_c;
    logic [WIDTH-1:0] quo_c;
    logic [WIDTH-1:0] rem_c;

    assign op_c      = md_op_e'(op);
    assign signed_c  = (op_c == MD_MULT) || (op_c == MD_DIV);
    assign is_div_c  = (op_c == MD_DIV) || (op_c == MD_DIVU);
    assign run_div_c = (op_q == MD_DIV) || (op_q == MD_DIVU);

    // Operand magnitudes; unsigned ops pass through untouched.
    md_neg #(.W(WIDTH)) u_neg_a (
        .x_i   (a),
        .neg_i (signed_c & a[WIDTH-1]),
        .y_c   (a_mag_c)
    );

    md_neg #(.W(WIDTH)) u_neg_b (
        .x_i   (b),
        .neg_i (signed_c & b[WIDTH-1]),
        .y_c   (b_mag_c)
    );

    // Shift-add step: conditionally add multiplicand to upper half, shift right.
    assign sum_c      = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
    assign mul_next_c = {sum_c, acc_q[WIDTH-1:1]};

    // Restoring step: upper half is the remainder, lower half shifts dividend out / quotient in.
    assign trial_c    = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    assign diff_c     = trial_c - {1'b0, opnd_q};
    assign ge_c       = ~diff_c[WIDTH];
    assign div_next_c = {(ge_c ? diff_c[WIDTH-1:0] : trial_c[WIDTH-1:0]), acc_q[WIDTH-2:0], ge_c};

    md_neg #(.W(W2)) u_neg_prod (
        .x_i   (acc_q),
        .neg_i (sq_q),
        .y_c   (prod_c)
    );

    md_neg #(.W(WIDTH)) u_neg_quo (
        .x_i   (acc_q[WIDTH-1:0]),
        .neg_i (sq_q),
        .y_c   (quo_c)
    );

    md_neg #(.W(WIDTH)) u_neg_rem (
        .x_i   (acc_q[W2-1:WIDTH]),
        .neg_i (sr_q),
        .y_c   (rem_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        dz_d    = dz_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        divz_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = op_c;
                    sq_d   = signed_c & (a[WIDTH-1] ^ b[WIDTH-1]);
                    sr_d   = signed_c & a[WIDTH-1];
                    busy_d = 1'b1;
                    acc_d  = {{WIDTH{1'b0}}, (is_div_c ? a_mag_c : b_mag_c)};
                    opnd_d = is_div_c ? b_mag_c : a_mag_c;
                    if (is_div_c && (b == '0)) begin
                        dz_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_FIX;
                    end else begin
                        dz_d    = 1'b0;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                acc_d = run_div_c ? div_next_c : mul_next_c;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dz_d    = 1'b0;
                if (dz_q) begin
                    divz_d = 1'b1;
                end else if (run_div_c) begin
                    hi_d = rem_c;
                    lo_d = quo_c;
                end else begin
                    {hi_d, lo_d} = prod_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULT;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            dz_q    <= 1'b0;
            acc_q   <= '0;
            opnd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            dz_q    <= dz_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = divz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] ref_hi = '0;
    logic [W-1:0] ref_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op_i),
        .a        (a_i),
        .b        (b_i),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic; SV division truncates toward zero, remainder follows dividend.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                  output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(aa));
        sb = longint'($signed(bb));
        h  = ref_hi;
        l  = ref_lo;
        dz = 1'b0;
        case (o)
            2'd0: begin
                p = 64'(sa * sb);
                {h, l} = p;
            end
            2'd1: begin
                p = {32'd0, aa} * {32'd0, bb};
                {h, l} = p;
            end
            2'd2: begin
                if (bb == '0) dz = 1'b1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            default: begin
                if (bb == '0) dz = 1'b1;
                else begin
                    l = aa / bb;
                    h = aa % bb;
                end
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or right after reset).
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input int pulse_at, input int rst_at);
        logic [W-1:0] eh, el;
        logic         edz;
        int           cyc;
        bit           seen;
        model(o, aa, bb, eh, el, edz);
        op_i  = o;
        a_i   = aa;
        b_i   = bb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 100) begin
            if (cyc == rst_at) begin
                reset = 1'b0;
                #1;
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_done", 64'(done), 64'(0));
                chk("rst_hi", 64'(hi), 64'(0));
                chk("rst_lo", 64'(lo), 64'(0));
                chk("rst_divz", 64'(div_zero), 64'(0));
                ref_hi = '0;
                ref_lo = '0;
                return;
            end
            start = (cyc == pulse_at);
            op_i  = 2'($urandom);
            a_i   = $urandom;
            b_i   = $urandom;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
            if (done) seen = 1;
        end
        chk("latency", 64'(cyc), edz ? 64'(1) : 64'(W + 1));
        chk("done_busy", 64'(busy), 64'(0));
        chk("div_zero", 64'(div_zero), 64'(edz));
        chk("hi", 64'(hi), 64'(eh));
        chk("lo", 64'(lo), 64'(el));
        ref_hi = eh;
        ref_lo = el;
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_divz", 64'(div_zero), 64'(0));
        chk("hold_hi", 64'(hi), 64'(ref_hi));
        chk("hold_lo", 64'(lo), 64'(ref_lo));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op_i  = '0;
        a_i   = '0;
        b_i   = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_divz", 64'(div_zero), 64'(0));
        chk("reset_hi", 64'(hi), 64'(0));
        chk("reset_lo", 64'(lo), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, -1, -1);
        chk("mult_neg3x7_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_neg3x7_lo", 64'(lo), 64'h0000_0000_FFFF_FFEB);
        idle_chk();
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        idle_chk();
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, -1, -1);
        idle_chk();
        run_op(2'd3, 32'h0000_0007, 32'h0000_0002, -1, -1);
        idle_chk();

        // Preload hi/lo = 1234/5678, then divide by zero back-to-back.
        run_op(2'd3, 32'h5678_1234, 32'h0001_0000, -1, -1);
        run_op(2'd3, 32'h0000_0007, 32'h0000_0000, -1, -1);
        chk("dz_hold_hi", 64'(hi), 64'h1234);
        chk("dz_hold_lo", 64'(lo), 64'h5678);
        idle_chk();

        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        idle_chk();

        run_op(2'd1, $urandom, $urandom, 10, -1);
        idle_chk();
        run_op(2'd1, 32'd6, 32'd7, -1, -1);
        chk("after_pulse_lo", 64'(lo), 64'h2A);
        idle_chk();

        run_op(2'd1, $urandom, $urandom, -1, 15);
        repeat (3) begin
            @(negedge clk);
            chk("in_reset_done", 64'(done), 64'(0));
            chk("in_reset_busy", 64'(busy), 64'(0));
        end
        start = 1'b1;
        reset = 1'b1;
        run_op(2'd1, 32'd6, 32'd7, -1, -1);
        chk("after_reset_lo", 64'(lo), 64'h2A);
        chk("after_reset_hi", 64'(hi), 64'h0);
        idle_chk();

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), pick(), pick(), -1, -1);
            if ($urandom_range(0, 1) == 0) idle_chk();
        end
        idle_chk();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
